bus_watch_unit: RTL and testbench
=================================

// Module: bus_watch_unit
// PURPOSE
//  Synthesisable on-chip debug monitor for the Niski SoC: snoops the CPU data bus and PC.
//  Captures writes that hit up to WINDOWS programmable address windows into a trace FIFO.
//  Each entry holds PC, address, data, byte mask, window id and a timestamp.
//  Up to BKPTS PC breakpoints; on a hit, runs on HOLD_CYCLES cycles, then asserts halt and freezes capture.
// PARAMETERS
//  ADDR_W       32   bus address / PC width
//  DATA_W       32   bus data width (multiple of 8)
//  WINDOWS      2    number of address-match windows (1..8)
//  BKPTS        2    number of PC breakpoints (1..8)
//  DEPTH        16   trace FIFO entries (power of 2, >=2)
//  HOLD_CYCLES  500  run-on cycles between trigger and halt (0 allowed)
// PORTS
//  clk         in   1                 system clock
//  rst_n       in   1                 synchronous active-low reset
//  bus_addr    in   ADDR_W            data bus address
//  bus_data    in   DATA_W            data bus write data
//  bus_mask    in   DATA_W/8          byte-enable mask
//  bus_wr      in   1                 write strobe (may stay high several cycles per write)
//  cpu_pc      in   ADDR_W            current PC
//  win_base    in   WINDOWS*ADDR_W    window i base, slice i
//  win_mask    in   WINDOWS*ADDR_W    window i compare mask (1 = bit compared)
//  win_en      in   WINDOWS           window enables
//  bp_pc       in   BKPTS*ADDR_W      breakpoint i PC, slice i
//  bp_en       in   BKPTS             breakpoint enables
//  resume      in   1                 leave HALTED
//  trc_valid   out  1                 FIFO head valid
//  trc_ready   in   1                 consumer pops head when valid&&ready
//  trc_pc/trc_addr/trc_data/trc_mask  out  ADDR_W/ADDR_W/DATA_W/DATA_W/8  head entry fields
//  trc_win     out  3                 matching window index
//  trc_time    out  32                timestamp of capture
//  ovf         out  1                 sticky: an entry was dropped
//  drop_cnt    out  16                dropped entries, saturating
//  ovf_clr     in   1                 clears ovf and drop_cnt
//  trig        out  1                 breakpoint hit (RUN_ON or HALTED)
//  trig_id     out  3                 index of hit breakpoint
//  halt        out  1                 high in HALTED
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): all outputs 0, FIFO empty, timestamp 0, FSM IDLE.
//    Reset wins over every other input, including mid-RUN_ON.
//  Timestamp: 32-bit free-running, +1 per cycle, wraps 0xFFFFFFFF->0.
//  Capture event: bus_wr && !wr_q (wr_q = bus_wr delayed 1 cycle), FSM != HALTED,
//    and some i with win_en[i] && ((bus_addr ^ base_i) & mask_i)==0.
//    Lowest matching i wins. All fields and timestamp are sampled in the event cycle.
//  Write held N cycles -> exactly one entry. Non-matching write -> no entry.
//  FIFO: show-ahead. An entry pushed to an empty FIFO gives trc_valid=1 on the next cycle.
//    Head fields are stable while valid && !ready.
//  Full FIFO with simultaneous pop and push: both occur, count unchanged.
//  Full FIFO with push and no pop: entry dropped; ovf<=1; drop_cnt<=min(drop_cnt+1, 0xFFFF).
//  ovf_clr: clears ovf and drop_cnt. If a drop occurs in the same cycle: ovf=1, drop_cnt=1.
//  FSM IDLE: on any bp_en[j] && cpu_pc==bp_j (lowest j wins): latch trig_id=j, cnt=HOLD_CYCLES.
//    Go to RUN_ON, or straight to HALTED if HOLD_CYCLES==0.
//  FSM RUN_ON: trig=1; cnt decrements each cycle; when cnt==1 -> HALTED.
//    halt rises exactly HOLD_CYCLES cycles after trig rises. Further PC matches are ignored.
//  FSM HALTED: trig=1, halt=1, capture disabled; FIFO still drains.
//    resume -> IDLE, trig/halt clear next cycle.
//  Re-arm guard: after resume, breakpoint trig_id cannot re-fire until cpu_pc != bp_trig_id for >=1 cycle.
//    Other breakpoints can fire immediately.
// TESTING
//  1. win0 base=0x70000020 mask=0xFFFFFFF0; write 0x70000024 data=0x2A mask=4'b1111, wr high 3 cycles
//     -> exactly one entry: addr=0x70000024, data=0x2A, win=0, trc_valid 1 cycle after edge.
//  2. Write 0x70000030 -> no entry. win1 base=0x70000030 mask=0xFFFFFFFF also enabled, write 0x70000030
//     -> entry with win=1. Overlapping windows -> win=0.
//  3. trc_ready=0, 17 matching writes -> 16 entries, ovf=1, drop_cnt=1.
//     Then 17th write coincident with pop -> accepted, drop_cnt stays 1. ovf_clr -> ovf=0, drop_cnt=0.
//  4. bp0=0x400011B4, cpu_pc reaches it at cycle T -> trig=1, trig_id=0 at T+1; halt=1 at T+1+500;
//     writes after halt not captured.
//  5. HOLD_CYCLES=0 -> halt at T+1. resume with pc held at 0x400011B4 -> no retrigger;
//     pc moves away and back -> retrigger.
//  6. rst_n=0 during RUN_ON with 3 FIFO entries -> trig=halt=trc_valid=0, timestamp=0 the next cycle.

Source files
------------

// File: rtl/bus_watch_unit.sv
// On-chip debug monitor: captures writes hitting address windows into a show-ahead trace FIFO
// and runs a PC-breakpoint trigger FSM (IDLE -> RUN_ON -> HALTED) that freezes capture.
module bus_watch_unit #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WINDOWS     = 2,
    parameter int BKPTS       = 2,
    parameter int DEPTH       = 16,
    parameter int HOLD_CYCLES = 500
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_W-1:0]         bus_addr,
    input  logic [DATA_W-1:0]         bus_data,
    input  logic [DATA_W/8-1:0]       bus_mask,
    input  logic                      bus_wr,
    input  logic [ADDR_W-1:0]         cpu_pc,
    input  logic [WINDOWS*ADDR_W-1:0] win_base,
    input  logic [WINDOWS*ADDR_W-1:0] win_mask,
    input  logic [WINDOWS-1:0]        win_en,
    input  logic [BKPTS*ADDR_W-1:0]   bp_pc,
    input  logic [BKPTS-1:0]          bp_en,
    input  logic                      resume,
    output logic                      trc_valid,
    input  logic                      trc_ready,
    output logic [ADDR_W-1:0]         trc_pc,
    output logic [ADDR_W-1:0]         trc_addr,
    output logic [DATA_W-1:0]         trc_data,
    output logic [DATA_W/8-1:0]       trc_mask,
    output logic [2:0]                trc_win,
    output logic [31:0]               trc_time,
    output logic                      ovf,
    output logic [15:0]               drop_cnt,
    input  logic                      ovf_clr,
    output logic                      trig,
    output logic [2:0]                trig_id,
    output logic                      halt
);
    localparam int MW = DATA_W / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [MW-1:0]     mask;
        logic [2:0]        win;
        logic [31:0]       ts;
    } entry_t;

    typedef enum logic [1:0] {IDLE, RUN_ON, HALTED} state_t;

    logic [31:0] ts_q;
    logic        wr_q;
    entry_t      mem_q [DEPTH];
    logic [AW:0] wptr_q, rptr_q;
    logic        ovf_q, ovf_d;
    logic [15:0] drop_q, drop_d;
    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  tid_q, tid_d;
    logic        guard_q, guard_d;

    logic        win_hit, bp_hit;
    logic [2:0]  win_idx, bp_idx;
    logic [ADDR_W-1:0] guard_pc;
    logic        empty, full, pop, cap, push, drop;
    entry_t      head;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        win_hit = 1'b0;
        win_idx = '0;
        for (int i = WINDOWS - 1; i >= 0; i--) begin
            if (win_en[i] && (((bus_addr ^ win_base[i*ADDR_W +: ADDR_W]) & win_mask[i*ADDR_W +: ADDR_W]) == '0)) begin
                win_hit = 1'b1;
                win_idx = 3'(i);
            end
        end
    end

    // The last-fired breakpoint is masked after resume until the PC leaves it.
    always_comb begin
        bp_hit   = 1'b0;
        bp_idx   = '0;
        guard_pc = '0;
        for (int j = BKPTS - 1; j >= 0; j--) begin
            if (tid_q == 3'(j))
                guard_pc = bp_pc[j*ADDR_W +: ADDR_W];
            if (bp_en[j] && (cpu_pc == bp_pc[j*ADDR_W +: ADDR_W]) && !(guard_q && (tid_q == 3'(j)))) begin
                bp_hit = 1'b1;
                bp_idx = 3'(j);
            end
        end
    end

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop   = !empty && trc_ready;
    assign cap   = bus_wr && !wr_q && (state_q != HALTED) && win_hit;
    assign push  = cap && (!full || pop);
    assign drop  = cap && full && !pop;

    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (ovf_clr) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
        if (drop) begin
            ovf_d  = 1'b1;
            drop_d = ovf_clr ? 16'd1 : ((drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tid_d   = tid_q;
        guard_d = guard_q;
        if (guard_q && (cpu_pc != guard_pc))
            guard_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bp_hit) begin
                    tid_d   = bp_idx;
                    cnt_d   = CW'(HOLD_CYCLES);
                    guard_d = 1'b0;
                    state_d = (HOLD_CYCLES == 0) ? HALTED : RUN_ON;
                end
            end
            RUN_ON: begin
                if (cnt_q <= CW'(1))
                    state_d = HALTED;
                else
                    cnt_d = cnt_q - CW'(1);
            end
            HALTED: begin
                if (resume) begin
                    state_d = IDLE;
                    guard_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_q    <= '0;
            wr_q    <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            tid_q   <= '0;
            guard_q <= 1'b0;
        end else begin
            ts_q    <= ts_q + 32'd1;
            wr_q    <= bus_wr;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tid_q   <= tid_d;
            guard_q <= guard_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q[AW-1:0]] <= '{pc: cpu_pc, addr: bus_addr, data: bus_data,
                                       mask: bus_mask, win: win_idx, ts: ts_q};
    end

    // Head fields are gated so every output reads zero while the FIFO is empty.
    assign head      = mem_q[rptr_q[AW-1:0]];
    assign trc_valid = !empty;
    assign trc_pc    = trc_valid ? head.pc   : '0;
    assign trc_addr  = trc_valid ? head.addr : '0;
    assign trc_data  = trc_valid ? head.data : '0;
    assign trc_mask  = trc_valid ? head.mask : '0;
    assign trc_win   = trc_valid ? head.win  : '0;
    assign trc_time  = trc_valid ? head.ts   : '0;
    assign ovf       = ovf_q;
    assign drop_cnt  = drop_q;
    assign trig      = (state_q != IDLE);
    assign halt      = (state_q == HALTED);
    assign trig_id   = tid_q;
endmodule

// File: tb/tb_bus_watch_unit.sv
// Bench for bus_watch_unit: scoreboard queue of expected trace entries checked by a monitor
// thread, plus directed checks of overflow, trigger timing, re-arm guard and reset.
`timescale 1ns/1ps
module tb_bus_watch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] bus_addr, bus_data, cpu_pc;
    logic [3:0]  bus_mask;
    logic        bus_wr, resume, ovf_clr, trc_ready;
    logic [63:0] win_base, win_mask, bp_pc;
    logic [1:0]  win_en, bp_en_a, bp_en_b;
    logic [1:0]  win_en_b = 2'b00;
    logic        trc_ready_b = 1'b1;

    logic        a_valid, a_ovf, a_trig, a_halt;
    logic [31:0] a_pc, a_addr, a_data, a_time;
    logic [3:0]  a_mask;
    logic [2:0]  a_win, a_tid;
    logic [15:0] a_drop;
    logic        b_valid, b_ovf, b_trig, b_halt;
    logic [31:0] b_pc, b_addr, b_data, b_time;
    logic [3:0]  b_mask;
    logic [2:0]  b_win, b_tid;
    logic [15:0] b_drop;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [2:0]  win;
        logic [31:0] ts;
    } exp_t;
    exp_t exp_q[$];

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] tb_ts;

    always #5 clk = ~clk;

    // Reference timestamp: cycles since the last reset edge.
    always @(posedge clk) tb_ts <= !rst_n ? 32'd0 : tb_ts + 32'd1;

    bus_watch_unit #(.HOLD_CYCLES(500)) u_a (
        .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_data(bus_data), .bus_mask(bus_mask),
        .bus_wr(bus_wr), .cpu_pc(cpu_pc), .win_base(win_base), .win_mask(win_mask), .win_en(win_en),
        .bp_pc(bp_pc), .bp_en(bp_en_a), .resume(resume), .trc_valid(a_valid), .trc_ready(trc_ready),
        .trc_pc(a_pc), .trc_addr(a_addr), .trc_data(a_data), .trc_mask(a_mask), .trc_win(a_win),
        .trc_time(a_time), .ovf(a_ovf), .drop_cnt(a_drop), .ovf_clr(ovf_clr), .trig(a_trig),
        .trig_id(a_tid), .halt(a_halt));

    bus_watch_unit #(.HOLD_CYCLES(0)) u_b (
        .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_data(bus_data), .bus_mask(bus_mask),
        .bus_wr(bus_wr), .cpu_pc(cpu_pc), .win_base(win_base), .win_mask(win_mask), .win_en(win_en_b),
        .bp_pc(bp_pc), .bp_en(bp_en_b), .resume(resume), .trc_valid(b_valid), .trc_ready(trc_ready_b),
        .trc_pc(b_pc), .trc_addr(b_addr), .trc_data(b_data), .trc_mask(b_mask), .trc_win(b_win),
        .trc_time(b_time), .ovf(b_ovf), .drop_cnt(b_drop), .ovf_clr(ovf_clr), .trig(b_trig),
        .trig_id(b_tid), .halt(b_halt));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                      input int hold, input bit exp_e, input logic [2:0] w);
        exp_t e;
        bus_addr = a; bus_data = d; bus_mask = m; bus_wr = 1'b1;
        if (exp_e) begin
            e.pc = cpu_pc; e.addr = a; e.data = d; e.mask = m; e.win = w; e.ts = tb_ts;
            exp_q.push_back(e);
        end
        repeat (hold) tick();
        bus_wr = 1'b0;
        tick();
    endtask

    task automatic drain(input string nm);
        trc_ready = 1'b1;
        repeat (20) tick();
        chk(nm, {63'd0, a_valid}, 64'd0);
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; bus_addr = '0; bus_data = '0; bus_mask = '0; bus_wr = 1'b0;
        cpu_pc = 32'h40000100; resume = 1'b0; ovf_clr = 1'b0; trc_ready = 1'b0;
        win_base = {32'h0, 32'h70000020}; win_mask = {32'h0, 32'hFFFFFFF0}; win_en = 2'b00;
        bp_pc = {32'h40002000, 32'h400011B4}; bp_en_a = 2'b00; bp_en_b = 2'b00;

        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (rst_n && a_valid && trc_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("pop.unexpected_entry", {32'd0, a_addr}, 64'hFFFFFFFF_FFFFFFFF);
                        end else begin
                            e = exp_q.pop_front();
                            chk("pop.pc",   {32'd0, a_pc},   {32'd0, e.pc});
                            chk("pop.addr", {32'd0, a_addr}, {32'd0, e.addr});
                            chk("pop.data", {32'd0, a_data}, {32'd0, e.data});
                            chk("pop.mask", {60'd0, a_mask}, {60'd0, e.mask});
                            chk("pop.win",  {61'd0, a_win},  {61'd0, e.win});
                            chk("pop.time", {32'd0, a_time}, {32'd0, e.ts});
                        end
                    end
                end
            end
            begin : watchdog
                #2_000_000;
                $display("FAIL watchdog: actual=timeout required=finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        repeat (2) tick();
        chk("reset.valid", {63'd0, a_valid}, 64'd0);
        chk("reset.ovf",   {63'd0, a_ovf},   64'd0);
        chk("reset.drop",  {48'd0, a_drop},  64'd0);
        chk("reset.trig",  {63'd0, a_trig},  64'd0);
        chk("reset.halt",  {63'd0, a_halt},  64'd0);
        chk("reset.pc",    {32'd0, a_pc},    64'd0);
        rst_n = 1'b1;
        tick();

        // 1: one entry for a write held high three cycles
        win_en = 2'b01;
        bus_addr = 32'h70000024; bus_data = 32'h2A; bus_mask = 4'b1111; bus_wr = 1'b1;
        e.pc = cpu_pc; e.addr = 32'h70000024; e.data = 32'h2A; e.mask = 4'hF; e.win = 3'd0; e.ts = tb_ts;
        exp_q.push_back(e);
        chk("t1.valid_before", {63'd0, a_valid}, 64'd0);
        tick();
        chk("t1.valid_after", {63'd0, a_valid}, 64'd1);
        tick(); tick();
        bus_wr = 1'b0;
        tick();
        trc_ready = 1'b1;
        tick(); tick();
        chk("t1.single_entry", {63'd0, a_valid}, 64'd0);

        // 2: window miss, second window, overlap priority
        wr(32'h70000030, 32'h55, 4'h3, 1, 1'b0, 3'd0);
        win_base = {32'h70000030, 32'h70000020}; win_mask = {32'hFFFFFFFF, 32'hFFFFFFF0}; win_en = 2'b11;
        wr(32'h70000030, 32'h11, 4'h1, 1, 1'b1, 3'd1);
        win_base = {32'h70000000, 32'h70000020}; win_mask = {32'hFFFFFF00, 32'hFFFFFFF0};
        wr(32'h70000028, 32'h22, 4'hC, 2, 1'b1, 3'd0);
        wr(32'h70000050, 32'h33, 4'h8, 1, 1'b1, 3'd1);
        drain("t2.drained");

        // 3: overflow, coincident pop/push at full, ovf_clr
        win_en = 2'b01;
        trc_ready = 1'b0;
        for (int i = 0; i < 17; i++)
            wr(32'h70000020 | 32'(i % 16), 32'hD0000000 + 32'(i), 4'hF, 1, (i < 16), 3'd0);
        chk("t3.ovf",  {63'd0, a_ovf},  64'd1);
        chk("t3.drop", {48'd0, a_drop}, 64'd1);
        trc_ready = 1'b1;
        bus_addr = 32'h70000027; bus_data = 32'hBEEF; bus_mask = 4'h5; bus_wr = 1'b1;
        e.pc = cpu_pc; e.addr = 32'h70000027; e.data = 32'hBEEF; e.mask = 4'h5; e.win = 3'd0; e.ts = tb_ts;
        exp_q.push_back(e);
        tick();
        trc_ready = 1'b0; bus_wr = 1'b0;
        tick();
        chk("t3.drop_after_coincident", {48'd0, a_drop}, 64'd1);
        ovf_clr = 1'b1; bus_addr = 32'h7000002A; bus_wr = 1'b1;
        tick();
        ovf_clr = 1'b0; bus_wr = 1'b0;
        tick();
        chk("t3.clr_with_drop.ovf",  {63'd0, a_ovf},  64'd1);
        chk("t3.clr_with_drop.drop", {48'd0, a_drop}, 64'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t3.clr.ovf",  {63'd0, a_ovf},  64'd0);
        chk("t3.clr.drop", {48'd0, a_drop}, 64'd0);
        drain("t3.drained");

        // 4: breakpoint 0 with 500-cycle run-on
        bp_en_a = 2'b01;
        cpu_pc = 32'h400011B4;
        chk("t4.trig_before", {63'd0, a_trig}, 64'd0);
        tick();
        cpu_pc = 32'h40000100;
        chk("t4.trig",    {63'd0, a_trig}, 64'd1);
        chk("t4.trig_id", {61'd0, a_tid},  64'd0);
        chk("t4.halt_early", {63'd0, a_halt}, 64'd0);
        repeat (499) tick();
        chk("t4.halt_T+500", {63'd0, a_halt}, 64'd0);
        tick();
        chk("t4.halt_T+501", {63'd0, a_halt}, 64'd1);
        wr(32'h70000021, 32'h99, 4'hF, 1, 1'b0, 3'd0);
        drain("t4.no_capture_halted");
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("t4.resume.trig", {63'd0, a_trig}, 64'd0);
        chk("t4.resume.halt", {63'd0, a_halt}, 64'd0);
        bp_en_a = 2'b00;

        // 5: zero run-on and re-arm guard
        bp_en_b = 2'b01;
        cpu_pc = 32'h400011B4;
        tick();
        chk("t5.trig", {63'd0, b_trig}, 64'd1);
        chk("t5.halt", {63'd0, b_halt}, 64'd1);
        chk("t5.trig_id", {61'd0, b_tid}, 64'd0);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("t5.resume.trig", {63'd0, b_trig}, 64'd0);
        repeat (3) tick();
        chk("t5.guard_no_retrig", {63'd0, b_trig}, 64'd0);
        cpu_pc = 32'h40000100;
        tick();
        cpu_pc = 32'h400011B4;
        tick();
        chk("t5.retrig", {63'd0, b_trig}, 64'd1);
        chk("t5.rehalt", {63'd0, b_halt}, 64'd1);
        cpu_pc = 32'h40000100;
        bp_en_b = 2'b00;

        // 6: reset mid run-on with entries queued
        trc_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            wr(32'h70000020 + 32'(i), 32'h600 + 32'(i), 4'hF, 1, 1'b0, 3'd0);
        bp_en_a = 2'b10;
        cpu_pc = 32'h40002000;
        tick();
        cpu_pc = 32'h40000100;
        tick();
        chk("t6.pre.trig",    {63'd0, a_trig},  64'd1);
        chk("t6.pre.trig_id", {61'd0, a_tid},   64'd1);
        chk("t6.pre.valid",   {63'd0, a_valid}, 64'd1);
        rst_n = 1'b0;
        tick();
        chk("t6.rst.trig",  {63'd0, a_trig},  64'd0);
        chk("t6.rst.halt",  {63'd0, a_halt},  64'd0);
        chk("t6.rst.valid", {63'd0, a_valid}, 64'd0);
        chk("t6.rst.tid",   {61'd0, a_tid},   64'd0);
        exp_q.delete();
        rst_n = 1'b1; trc_ready = 1'b1;
        bus_addr = 32'h70000021; bus_data = 32'h77; bus_mask = 4'h2; bus_wr = 1'b1;
        e.pc = 32'h40000100; e.addr = 32'h70000021; e.data = 32'h77; e.mask = 4'h2; e.win = 3'd0; e.ts = 32'd0;
        exp_q.push_back(e);
        tick();
        bus_wr = 1'b0;
        chk("t6.trig_after_reset", {63'd0, a_trig}, 64'd0);
        drain("t6.drained");
        chk("end.scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
